// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS trace capture block.
//   - FSM state encoding (also the value presented on state_out)
//   - 96-bit trace entry layout: pc [95:64], ula [63:32], dmem [31:0]
//   - default buffer depth and post-trigger window
package mips_trace_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_POST_TRIG = 8;
  localparam int ENTRY_W       = 96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  // Packed so that pc lands in [95:64], ula in [63:32], dmem in [31:0].
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ula;
    logic [31:0] dmem;
  } entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x 96-bit trace storage.
//   clock  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : entry to write
//   raddr  : read address
//   rdata  : entry at raddr (combinational)
// Contents are deliberately not reset.
module trace_ram
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_trace_capture.sv
// In-fabric trace recorder for the single-cycle MIPS core.
// Samples {pc, ula, dmem} every cycle into a circular buffer once armed,
// freezes POST_TRIG samples after a PC-match trigger, then drains the
// buffer oldest-first over a valid/ready port.
//   clock, reset            : single clock, synchronous active-high reset
//   arm                     : pulse in IDLE to start a capture session
//   trig_pc                 : PC value that fires the trigger
//   current_pc_value_in,
//   ula_result_in,
//   d_mem_read_in           : core observation inputs
//   rd_valid/rd_ready       : readout handshake (FROZEN only)
//   rd_pc/rd_ula/rd_dmem    : entry at the read pointer, 0 when not valid
//   entry_count             : valid entries held
//   triggered               : trigger fired in the current session
//   state_out               : IDLE=0, ARMED=1, POST=2, FROZEN=3
module mips_trace_capture
  import mips_trace_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 4,
  parameter int POST_TRIG = DEF_POST_TRIG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic [31:0]       trig_pc,
  input  logic [31:0]       current_pc_value_in,
  input  logic [31:0]       ula_result_in,
  input  logic [31:0]       d_mem_read_in,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_pc,
  output logic [31:0]       rd_ula,
  output logic [31:0]       rd_dmem,
  output logic [ADDR_W:0]   entry_count,
  output logic              triggered,
  output logic [1:0]        state_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              trig_q, trig_d;

  logic              we;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W:0]   cnt_inc;
  logic              hit;
  entry_t            wdata, rdata;

  assign wdata   = '{pc: current_pc_value_in, ula: ula_result_in, dmem: d_mem_read_in};
  assign wr_next = wr_ptr_q + ADDR_W'(1);
  assign cnt_inc = (count_q == (ADDR_W+1)'(DEPTH)) ? count_q : count_q + (ADDR_W+1)'(1);
  assign hit     = (current_pc_value_in == trig_pc);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    count_d    = count_q;
    trig_d     = trig_q;
    we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        we       = 1'b1;
        wr_ptr_d = wr_next;
        count_d  = cnt_inc;
        if (hit) begin
          trig_d = 1'b1;
          if (POST_TRIG == 0) begin
            state_d  = ST_FROZEN;
            // Oldest entry; when full the low bits of cnt_inc are 0 so this
            // points at the slot the next write would have overwritten.
            rd_ptr_d = wr_next - cnt_inc[ADDR_W-1:0];
          end else begin
            state_d    = ST_POST;
            post_cnt_d = ADDR_W'(POST_TRIG);
          end
        end
      end
      ST_POST: begin
        we         = 1'b1;
        wr_ptr_d   = wr_next;
        count_d    = cnt_inc;
        post_cnt_d = post_cnt_q - ADDR_W'(1);
        if (post_cnt_q == ADDR_W'(1)) begin
          state_d  = ST_FROZEN;
          rd_ptr_d = wr_next - cnt_inc[ADDR_W-1:0];
        end
      end
      ST_FROZEN: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          count_d  = count_q - (ADDR_W+1)'(1);
          if (count_q == (ADDR_W+1)'(1)) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
      trig_q     <= trig_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Outputs are forced to 0 when not valid so the RAM's unreset contents
  // never leak out.
  assign rd_valid    = (state_q == ST_FROZEN) && (count_q != '0);
  assign rd_pc       = rd_valid ? rdata.pc   : '0;
  assign rd_ula      = rd_valid ? rdata.ula  : '0;
  assign rd_dmem     = rd_valid ? rdata.dmem : '0;
  assign entry_count = count_q;
  assign triggered   = trig_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed bench for mips_trace_capture: main instance with default
// POST_TRIG=8, second instance with POST_TRIG=0.
module tb_mips_trace_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] ula, dmem;

  logic        arm, rd_ready;
  logic [31:0] trig_pc;
  logic        rd_valid, triggered;
  logic [31:0] rd_pc, rd_ula, rd_dmem;
  logic [4:0]  entry_count;
  logic [1:0]  state_out;

  logic        arm2, rd_ready2;
  logic [31:0] trig_pc2;
  logic        rd_valid2, triggered2;
  logic [31:0] rd_pc2, rd_ula2, rd_dmem2;
  logic [4:0]  entry_count2;
  logic [1:0]  state_out2;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ULA_MASK = 32'hA5A5_0000;

  always #5 clock = ~clock;

  assign ula  = pc ^ ULA_MASK;
  assign dmem = ~pc;

  mips_trace_capture dut (
    .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc),
    .current_pc_value_in(pc), .ula_result_in(ula), .d_mem_read_in(dmem),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_ula(rd_ula),
    .rd_dmem(rd_dmem), .entry_count(entry_count), .triggered(triggered),
    .state_out(state_out)
  );

  mips_trace_capture #(.POST_TRIG(0)) dut2 (
    .clock(clock), .reset(reset), .arm(arm2), .trig_pc(trig_pc2),
    .current_pc_value_in(pc), .ula_result_in(ula), .d_mem_read_in(dmem),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_pc(rd_pc2), .rd_ula(rd_ula2),
    .rd_dmem(rd_dmem2), .entry_count(entry_count2), .triggered(triggered2),
    .state_out(state_out2)
  );

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  cnt;
    logic [1:0]  st;
  } vec_t;

  vec_t rv1 [17];
  vec_t rv2 [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the core PC steps +4.
  task automatic tick();
    @(posedge clock);
    #1;
    pc = pc + 32'd4;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, v.vld});
    chk({tag, "_pc"},    rd_pc,   v.pc);
    chk({tag, "_ula"},   rd_ula,  v.vld ? (v.pc ^ ULA_MASK) : 32'd0);
    chk({tag, "_dmem"},  rd_dmem, v.vld ? ~v.pc : 32'd0);
    chk({tag, "_cnt"},   {27'd0, entry_count}, {27'd0, v.cnt});
    chk({tag, "_state"}, {30'd0, state_out},   {30'd0, v.st});
    rd_ready = v.rdy;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  pulsed;

    // Readout of basic capture: 0x04..0x40, then IDLE.
    for (int i = 0; i < 16; i++)
      rv1[i] = '{1'b1, 1'b1, 32'h04 + 32'(4*i), 5'(16-i), 2'd3};
    rv1[16] = '{1'b0, 1'b0, 32'h0, 5'd0, 2'd0};
    // Overwrite readout with backpressure 1,0,0,1, then drain 0x6C..0xA0.
    rv2[0] = '{1'b1, 1'b1, 32'h64, 5'd16, 2'd3};
    rv2[1] = '{1'b0, 1'b1, 32'h68, 5'd15, 2'd3};
    rv2[2] = '{1'b0, 1'b1, 32'h68, 5'd15, 2'd3};
    rv2[3] = '{1'b1, 1'b1, 32'h68, 5'd15, 2'd3};
    for (int i = 0; i < 14; i++)
      rv2[4+i] = '{1'b1, 1'b1, 32'h6C + 32'(4*i), 5'(14-i), 2'd3};
    rv2[18] = '{1'b0, 1'b0, 32'h0, 5'd0, 2'd0};

    reset = 1'b1; arm = 1'b0; arm2 = 1'b0; rd_ready = 1'b0; rd_ready2 = 1'b0;
    trig_pc = 32'hFFFF_FFFF; trig_pc2 = 32'hFFFF_FFFF; pc = 32'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_cnt",   {27'd0, entry_count}, 32'd0);
    chk("rst_trig",  {31'd0, triggered}, 32'd0);
    chk("rst_rdpc",  rd_pc, 32'd0);
    chk("rst_rdula", rd_ula, 32'd0);

    // ---- Basic capture, arm ignored in POST and FROZEN ----
    pc = 32'h0; trig_pc = 32'h20;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_armed", {30'd0, state_out}, 32'd1);
    n = 0; pulsed = 0;
    while (state_out != 2'd3 && n < 64) begin
      if (state_out == 2'd2 && !pulsed) begin
        arm = 1'b1; pulsed = 1; tick(); arm = 1'b0; n++;
        chk("t1_post_arm_ignored", {30'd0, state_out}, 32'd2);
      end else begin
        tick(); n++;
      end
    end
    chk("t1_cycles_to_frozen", 32'(n), 32'd16);
    chk("t1_cnt",  {27'd0, entry_count}, 32'd16);
    chk("t1_trig", {31'd0, triggered}, 32'd1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_frozen_arm_state", {30'd0, state_out}, 32'd3);
    chk("t1_frozen_arm_cnt",   {27'd0, entry_count}, 32'd16);
    chk("t1_frozen_arm_pc",    rd_pc, 32'h04);
    for (int i = 0; i < 17; i++) run_vec($sformatf("t1_rd%0d", i), rv1[i]);
    chk("t1_trig_clear", {31'd0, triggered}, 32'd0);

    // ---- Overwrite + backpressure ----
    pc = 32'h0; trig_pc = 32'h80;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t2_sat_state", {30'd0, state_out}, 32'd1);
    chk("t2_sat_cnt",   {27'd0, entry_count}, 32'd16);
    n = 0;
    while (state_out != 2'd3 && n < 64) begin tick(); n++; end
    chk("t2_cycles_to_frozen", 32'(n), 32'd20);
    for (int i = 0; i < 19; i++) run_vec($sformatf("t2_rd%0d", i), rv2[i]);

    // ---- arm + PC match in IDLE, then reset mid-readout ----
    trig_pc = pc;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t3_armed",   {30'd0, state_out}, 32'd1);
    chk("t3_no_trig", {31'd0, triggered}, 32'd0);
    trig_pc = pc + 32'd4;
    n = 0;
    while (state_out != 2'd3 && n < 32) begin tick(); n++; end
    chk("t3_cycles_to_frozen", 32'(n), 32'd10);
    chk("t3_cnt", {27'd0, entry_count}, 32'd10);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("t3_cnt_after_xfer", {27'd0, entry_count}, 32'd9);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t3_rst_state", {30'd0, state_out}, 32'd0);
    chk("t3_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("t3_rst_cnt",   {27'd0, entry_count}, 32'd0);
    chk("t3_rst_trig",  {31'd0, triggered}, 32'd0);
    tick();
    chk("t3_idle_valid", {31'd0, rd_valid}, 32'd0);

    // ---- POST_TRIG=0 instance ----
    pc = 32'h0; trig_pc2 = 32'h0C;
    arm2 = 1'b1; tick(); arm2 = 1'b0;
    n = 0;
    while (state_out2 != 2'd3 && n < 16) begin tick(); n++; end
    chk("t4_cycles_to_frozen", 32'(n), 32'd3);
    chk("t4_cnt",  {27'd0, entry_count2}, 32'd3);
    chk("t4_trig", {31'd0, triggered2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_valid%0d", i), {31'd0, rd_valid2}, 32'd1);
      chk($sformatf("t4_pc%0d", i), rd_pc2, 32'h04 + 32'(4*i));
      rd_ready2 = 1'b1; tick(); rd_ready2 = 1'b0;
    end
    chk("t4_end_state", {30'd0, state_out2}, 32'd0);
    chk("t4_end_cnt",   {27'd0, entry_count2}, 32'd0);
    chk("t4_end_valid", {31'd0, rd_valid2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
